// File: rtl/ex_issue_stage.sv
// Purpose: pipeline register + operand select ahead of the ALU (forwarding, imm mux, ALU control decode).
// Latency: 1 cycle from decode handshake to registered a/b/control.
// Backpressure: ready_out = !valid_out || ready_in; a held instruction re-applies forwarding each stalled cycle.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   valid_in / ready_out  decode-side handshake
//   rs1_*/rs2_*/imm       source indices, register file data, immediate
//   alusrc, aluop, funct3, funct7_5   operand-B select and ALU decode inputs
//   flush                 squash held and incoming instruction
//   exmem_*/memwb_*       forwarding sources (EX/MEM has priority)
//   valid_out / ready_in  ALU-side handshake
//   a, b, control, illegal_op   registered ALU operands and control code
module ex_issue_stage #(
  parameter int XLEN   = 64,
  parameter int REGIDX = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [REGIDX-1:0] rs1_idx,
  input  logic [REGIDX-1:0] rs2_idx,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm,
  input  logic              alusrc,
  input  logic [1:0]        aluop,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic              flush,
  input  logic              exmem_regwrite,
  input  logic [REGIDX-1:0] exmem_rd,
  input  logic [XLEN-1:0]   exmem_data,
  input  logic              memwb_regwrite,
  input  logic [REGIDX-1:0] memwb_rd,
  input  logic [XLEN-1:0]   memwb_data,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [XLEN-1:0]   a,
  output logic [XLEN-1:0]   b,
  output logic [3:0]        control,
  output logic              illegal_op
);

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_PASS = 4'b0111;
  localparam logic [3:0] CTL_ILL  = 4'b1111;

  // Captured source info so a stalled instruction can keep picking up forwards.
  logic [REGIDX-1:0] rs1_q, rs2_q;
  logic              alusrc_q;

  logic load, hold;
  logic [REGIDX-1:0] src1_idx, src2_idx;
  logic [XLEN-1:0]   fwd1, fwd2, opb;
  logic [3:0]        ctl_d;
  logic              ill_d;

  // Forwarding priority: x0 never forwards, EX/MEM beats MEM/WB, else base.
  function automatic logic [XLEN-1:0] fwd(input logic [REGIDX-1:0] idx,
                                          input logic [XLEN-1:0]   base);
    if (idx == '0)
      return base;
    else if (exmem_regwrite && exmem_rd == idx)
      return exmem_data;
    else if (memwb_regwrite && memwb_rd == idx)
      return memwb_data;
    else
      return base;
  endfunction

  assign ready_out = !valid_out || ready_in;
  assign load      = valid_in && ready_out && !flush;
  assign hold      = valid_out && !ready_in;

  // Load and hold are mutually exclusive (hold implies ready_out=0), so one
  // forwarding path serves both: fresh indices/data on load, held ones on stall.
  // On stall the base is the currently held operand, so a miss keeps it.
  assign src1_idx = load ? rs1_idx : rs1_q;
  assign src2_idx = load ? rs2_idx : rs2_q;
  assign fwd1     = fwd(src1_idx, load ? rs1_data : a);
  assign fwd2     = fwd(src2_idx, load ? rs2_data : b);
  assign opb      = alusrc ? imm : fwd2;

  always_comb begin
    ctl_d = CTL_ADD;
    ill_d = 1'b0;
    case (aluop)
      2'b00: ctl_d = CTL_ADD;
      2'b01: ctl_d = CTL_SUB;
      2'b11: ctl_d = CTL_PASS;
      default: begin
        case (funct3)
          3'b000:  ctl_d = (funct7_5 && !alusrc) ? CTL_SUB : CTL_ADD;
          3'b111:  ctl_d = CTL_AND;
          3'b110:  ctl_d = CTL_OR;
          default: begin
            ctl_d = CTL_ILL;
            ill_d = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out  <= 1'b0;
      a          <= '0;
      b          <= '0;
      control    <= 4'b0000;
      illegal_op <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      alusrc_q   <= 1'b0;
    end else if (flush) begin
      valid_out <= 1'b0;
    end else if (load) begin
      valid_out  <= 1'b1;
      a          <= fwd1;
      b          <= opb;
      control    <= ctl_d;
      illegal_op <= ill_d;
      rs1_q      <= rs1_idx;
      rs2_q      <= rs2_idx;
      alusrc_q   <= alusrc;
    end else if (valid_out && ready_in) begin
      // Drain: operands keep their last values.
      valid_out <= 1'b0;
    end else if (hold) begin
      a <= fwd1;
      if (!alusrc_q)
        b <= fwd2;
    end
  end

endmodule

// File: tb/tb_ex_issue_stage.sv
module tb_ex_issue_stage;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ctl;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in, ready_out, alusrc, funct7_5, flush;
  logic [4:0]  rs1_idx, rs2_idx, exmem_rd, memwb_rd;
  logic [63:0] rs1_data, rs2_data, imm, exmem_data, memwb_data;
  logic [1:0]  aluop;
  logic [2:0]  funct3;
  logic        exmem_regwrite, memwb_regwrite;
  logic        valid_out, ready_in, illegal_op;
  logic [63:0] a, b;
  logic [3:0]  control;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;

  ex_issue_stage #(.XLEN(64), .REGIDX(5)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .alusrc(alusrc), .aluop(aluop), .funct3(funct3), .funct7_5(funct7_5),
    .flush(flush), .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .exmem_data(exmem_data), .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data), .valid_out(valid_out), .ready_in(ready_in),
    .a(a), .b(b), .control(control), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    valid_in = 0; flush = 0; alusrc = 0; funct7_5 = 0; aluop = 0; funct3 = 0;
    rs1_idx = 0; rs2_idx = 0; rs1_data = 0; rs2_data = 0; imm = 0;
    exmem_regwrite = 0; exmem_rd = 0; exmem_data = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  // Push the hand-computed result, then present the instruction for one edge.
  task automatic send(input exp_t e);
    sb.push_back(e);
    valid_in = 1;
    @(posedge clk);
    #1 valid_in = 0;
  endtask

  // Monitor: every accepted transfer is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && valid_out && ready_in) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_xfer a=%h b=%h ctl=%b ill=%b", a, b, control, illegal_op);
      end else begin
        mon_e = sb.pop_front();
        if ({a, b, control, illegal_op} !== mon_e) begin
          failures++;
          $display("FAIL xfer actual a=%h b=%h ctl=%b ill=%b required a=%h b=%h ctl=%b ill=%b",
                   a, b, control, illegal_op, mon_e.a, mon_e.b, mon_e.ctl, mon_e.ill);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clear_in();
    ready_in = 1;
    @(negedge clk);
    chk("rst_valid", valid_out, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_ctl", control, 0);
    chk("rst_ill", illegal_op, 0);
    chk("rst_ready", ready_out, 1);
    @(posedge clk); #1 reset = 0;

    // R-type SUB, then same encoding with immediate -> ADD
    rs1_idx = 1; rs2_idx = 2; rs1_data = 10; rs2_data = 3;
    aluop = 2'b10; funct3 = 3'b000; funct7_5 = 1; alusrc = 0;
    send('{a:64'd10, b:64'd3, ctl:4'b0110, ill:1'b0});
    @(negedge clk);
    chk("latency_valid", valid_out, 1);
    alusrc = 1; imm = 5;
    send('{a:64'd10, b:64'd5, ctl:4'b0010, ill:1'b0});

    // Forward priority: EX/MEM wins over MEM/WB
    clear_in();
    rs1_idx = 4; rs1_data = 64'h11; rs2_idx = 2; rs2_data = 3;
    exmem_regwrite = 1; exmem_rd = 4; exmem_data = 64'hAA;
    memwb_regwrite = 1; memwb_rd = 4; memwb_data = 64'hBB;
    send('{a:64'hAA, b:64'd3, ctl:4'b0010, ill:1'b0});

    // x0 never forwards
    rs1_idx = 0; rs2_idx = 0; exmem_rd = 0; memwb_rd = 0;
    rs1_data = 64'h22; rs2_data = 64'h33; aluop = 2'b01;
    send('{a:64'h22, b:64'h33, ctl:4'b0110, ill:1'b0});

    // Illegal encoding, then a legal load clears the flag
    clear_in();
    rs1_data = 1; rs2_data = 2; aluop = 2'b10; funct3 = 3'b001;
    send('{a:64'd1, b:64'd2, ctl:4'b1111, ill:1'b1});
    aluop = 2'b11; alusrc = 1; imm = 64'h1000;
    send('{a:64'd1, b:64'h1000, ctl:4'b0111, ill:1'b0});

    // Hold refresh with ALUSRC=0: B picks up MEM/WB forward while stalled
    @(posedge clk); #1;
    clear_in();
    ready_in = 0;
    rs1_idx = 3; rs1_data = 64'h30; rs2_idx = 7; rs2_data = 64'h70;
    aluop = 2'b10; funct3 = 3'b111;
    send('{a:64'h30, b:64'h55, ctl:4'b0000, ill:1'b0});
    memwb_regwrite = 1; memwb_rd = 7; memwb_data = 64'h55;
    @(posedge clk); @(negedge clk);
    chk("hold_b_refresh", b, 64'h55);
    chk("hold_ctl_stable", control, 4'b0000);
    chk("hold_a_nomatch", a, 64'h30);
    memwb_regwrite = 0;
    @(posedge clk); @(negedge clk);
    chk("hold_b_keep", b, 64'h55);
    @(posedge clk); #1 ready_in = 1;
    @(posedge clk); #1;

    // Hold with ALUSRC=1: A refreshes, B stays IMM
    clear_in();
    ready_in = 0;
    rs1_idx = 7; rs1_data = 64'h71; rs2_idx = 7; rs2_data = 64'h72;
    alusrc = 1; imm = 64'h99; aluop = 2'b10; funct3 = 3'b110;
    send('{a:64'h55, b:64'h99, ctl:4'b0001, ill:1'b0});
    memwb_regwrite = 1; memwb_rd = 7; memwb_data = 64'h55;
    @(posedge clk); @(negedge clk);
    chk("hold_imm_a", a, 64'h55);
    chk("hold_imm_b", b, 64'h99);
    memwb_regwrite = 0;
    @(posedge clk); #1 ready_in = 1;

    // Streaming: 4 back-to-back loads, no bubble
    clear_in();
    for (int i = 0; i < 4; i++) begin
      rs1_data = 64'(i * 16 + 1); rs2_data = 64'(i);
      sb.push_back('{a:64'(i * 16 + 1), b:64'(i), ctl:4'b0010, ill:1'b0});
      valid_in = 1;
      @(posedge clk); @(negedge clk);
      chk("stream_valid", valid_out, 1);
    end
    valid_in = 0;
    @(posedge clk); #1;

    // Flush a held instruction together with an incoming one
    ready_in = 0;
    rs1_data = 64'hDEAD; valid_in = 1;
    @(posedge clk); #1 valid_in = 0;
    flush = 1; valid_in = 1;
    @(negedge clk);
    chk("flush_ready_out", ready_out, 0);
    @(posedge clk); #1 flush = 0; valid_in = 0;
    @(negedge clk);
    chk("flush_held_valid", valid_out, 0);
    @(posedge clk); #1 ready_in = 1;
    flush = 1; valid_in = 1;
    @(posedge clk); #1 flush = 0; valid_in = 0;
    @(negedge clk);
    chk("flush_in_valid", valid_out, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-hold
    ready_in = 0;
    rs1_data = 64'h44; rs2_data = 64'h45; valid_in = 1;
    @(posedge clk); #1 valid_in = 0;
    @(negedge clk);
    chk("pre_rst_valid", valid_out, 1);
    reset = 1;
    #1;
    chk("midrst_valid", valid_out, 0);
    chk("midrst_a", a, 0);
    chk("midrst_b", b, 0);
    chk("midrst_ctl", control, 0);
    @(posedge clk); #1 reset = 0; ready_in = 1;

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
